// File: rtl/synth_oscillator_pkg.sv
// Shared constants and types for the phase-accumulator oscillator.
package synth_oscillator_pkg;

    localparam int unsigned SYNTH_PHASE_ACC_BITS = 24;
    localparam int unsigned SYNTH_SAMPLE_BITS    = 16;

    typedef enum logic [1:0] {
        OSC_IDLE,
        OSC_RUN,
        OSC_RELEASE
    } osc_state_t;

    typedef enum logic [1:0] {
        WAVE_SAW,
        WAVE_SQUARE,
        WAVE_TRI,
        WAVE_SILENT
    } osc_wave_t;

endpackage

// File: rtl/synth_oscillator_wave_shaper.sv
// Combinational phase-to-sample shaper: saw, square, triangle or silence.
// The mute input forces zero (used while the oscillator is idle).
module osc_wave_shaper
    import synth_oscillator_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SYNTH_SAMPLE_BITS
) (
    input  logic [SYNTH_PHASE_ACC_BITS-1:0] phase_i,
    input  osc_wave_t                       wave_sel_i,
    input  logic                            mute_i,
    output logic [SAMPLE_BITS-1:0]          sample_c_o
);

    localparam int unsigned PMSB = SYNTH_PHASE_ACC_BITS - 1;
    localparam int unsigned SMSB = SAMPLE_BITS - 1;

    logic [SAMPLE_BITS-1:0] saw_t;
    logic [SAMPLE_BITS-1:0] tri_u;
    logic                   unused_phase_lsbs;

    // Fractional phase bits below the triangle window carry no audible weight.
    assign unused_phase_lsbs = ^phase_i[PMSB-SAMPLE_BITS-1:0];

    // Pick the waveform and convert offset-binary ramps to two's complement.
    always_comb begin
        saw_t = phase_i[PMSB -: SAMPLE_BITS];
        tri_u = phase_i[PMSB-1 -: SAMPLE_BITS];
        if (phase_i[PMSB]) begin
            tri_u = ~tri_u;
        end
        sample_c_o = '0;
        if (!mute_i) begin
            case (wave_sel_i)
                WAVE_SAW:    sample_c_o = {~saw_t[SMSB], saw_t[SMSB-1:0]};
                WAVE_SQUARE: sample_c_o = phase_i[PMSB] ? {1'b1, {SMSB{1'b0}}}
                                                        : {1'b0, {SMSB{1'b1}}};
                WAVE_TRI:    sample_c_o = {~tri_u[SMSB], tri_u[SMSB-1:0]};
                default:     sample_c_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/synth_oscillator.sv
// Phase-accumulator oscillator with click-free release and valid/ready output.
// Optional build macro SYNTH_OSC_SYNC_RETUNE_EN: pitch changes during a note
// are deferred to the next phase wrap (phase-continuous retune).
module synth_oscillator
    import synth_oscillator_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SYNTH_SAMPLE_BITS
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic [SYNTH_PHASE_ACC_BITS-1:0] phase_incr_in,
    input  logic                            sample_tick_in,
    input  logic [1:0]                      wave_sel_in,
    output logic [SAMPLE_BITS-1:0]          sample_out,
    output logic                            sample_valid_out,
    input  logic                            sample_ready_in,
    output logic                            active_out,
    output logic                            overrun_out
);

    localparam int unsigned PA = SYNTH_PHASE_ACC_BITS;

    osc_state_t             state_q, state_d;
    logic [PA-1:0]          phase_q, phase_d;
    logic [PA-1:0]          incr_q, incr_d;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
    logic [PA-1:0]          pend_q, pend_d;
    logic                   pend_v_q, pend_v_d;
`endif
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   active_q, active_d;
    logic                   overrun_q, overrun_d;

    logic                   note_on_c;
    logic [PA-1:0]          step_c;
    logic [PA:0]            sum_c;
    logic                   wrap_c;
    logic [SAMPLE_BITS-1:0] shaped_c;

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= OSC_IDLE;
            phase_q   <= '0;
            incr_q    <= '0;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
`endif
            sample_q  <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            incr_q    <= incr_d;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
`endif
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state, phase advance and increment/retune handling on sample ticks.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        incr_d    = incr_q;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
`endif
        note_on_c = (phase_incr_in != '0);
        step_c    = incr_q;
`ifndef SYNTH_OSC_SYNC_RETUNE_EN
        if ((state_q != OSC_IDLE) && note_on_c) begin
            step_c = phase_incr_in;
        end
`endif
        sum_c  = {1'b0, phase_q} + {1'b0, step_c};
        wrap_c = sum_c[PA];

        if (sample_tick_in) begin
            case (state_q)
                OSC_RUN, OSC_RELEASE: begin
                    phase_d = sum_c[PA-1:0];
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
                    // Deferred pitch takes effect after the wrap tick.
                    if (wrap_c && pend_v_q) begin
                        incr_d   = pend_q;
                        pend_v_d = 1'b0;
                    end
`endif
                    if (note_on_c) begin
                        state_d = OSC_RUN;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
                        if (phase_incr_in != incr_d) begin
                            pend_d   = phase_incr_in;
                            pend_v_d = 1'b1;
                        end else begin
                            pend_v_d = 1'b0;
                        end
`else
                        incr_d = phase_incr_in;
`endif
                    end else if (wrap_c) begin
                        state_d = OSC_IDLE;
                        phase_d = '0;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
                        pend_v_d = 1'b0;
`endif
                    end else begin
                        state_d = OSC_RELEASE;
                    end
                end
                default: begin
                    if (note_on_c) begin
                        incr_d  = phase_incr_in;
                        phase_d = phase_incr_in;
                        state_d = OSC_RUN;
                    end else begin
                        phase_d = '0;
                    end
                end
            endcase
        end
    end

    osc_wave_shaper #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) u_shaper (
        .phase_i    (phase_d),
        .wave_sel_i (osc_wave_t'(wave_sel_in)),
        .mute_i     (state_d == OSC_IDLE),
        .sample_c_o (shaped_c)
    );

    // Sample load, valid/ready handshake and sticky overrun flag.
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        active_d  = (state_d != OSC_IDLE);
        if (sample_tick_in) begin
            sample_d = shaped_c;
            valid_d  = 1'b1;
            if (valid_q && !sample_ready_in) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready_in) begin
            valid_d = 1'b0;
        end
    end

    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign active_out       = active_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_synth_oscillator.sv
// Self-checking bench for synth_oscillator: directed vector table, directed
// release/retune/reset sequences, and randomized traffic against a model.
module tb_synth_oscillator;

    logic        clk_in;
    logic        rst_n_in;
    logic [23:0] phase_incr_in;
    logic        sample_tick_in;
    logic [1:0]  wave_sel_in;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic        sample_ready_in;
    logic        active_out;
    logic        overrun_out;

    synth_oscillator dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .phase_incr_in    (phase_incr_in),
        .sample_tick_in   (sample_tick_in),
        .wave_sel_in      (wave_sel_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .active_out       (active_out),
        .overrun_out      (overrun_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // ---------------- behavioural reference model ----------------
    localparam int FULL = 16777216;   // 2^24 phase units per waveform cycle
    localparam int HALF = 8388608;

    int          m_mode;              // 0 idle, 1 run, 2 release
    int          m_phase;
    int          m_incr;
    int          m_pend;
    bit          m_pend_v;
    logic [15:0] m_sample;
    bit          m_valid;
    bit          m_over;

    function automatic logic [15:0] wave_ref(int p, int w);
        int v;
        case (w)
            0:       v = (p / 256) - 32768;
            1:       v = (p < HALF) ? 32767 : -32768;
            2:       v = ((p < HALF) ? p : (FULL - 1 - p)) / 128 - 32768;
            default: v = 0;
        endcase
        return 16'(v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_incr = 0; m_pend = 0; m_pend_v = 0;
        m_sample = '0; m_valid = 0; m_over = 0;
    endtask

    task automatic model_step(bit tick, int incr, int wave, bit ready);
        int  step;
        int  sum;
        bit  wrap;
        bit  on;
        on = (incr != 0);
        if (tick) begin
            if (m_mode == 0) begin
                if (on) begin m_incr = incr; m_phase = incr; m_mode = 1; end
                else m_phase = 0;
            end else begin
                step = m_incr;
`ifndef SYNTH_OSC_SYNC_RETUNE_EN
                if (on) begin m_incr = incr; step = incr; end
`endif
                sum     = m_phase + step;
                wrap    = (sum >= FULL);
                m_phase = sum % FULL;
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
                if (wrap && m_pend_v) begin m_incr = m_pend; m_pend_v = 0; end
                if (on) begin
                    if (incr != m_incr) begin m_pend = incr; m_pend_v = 1; end
                    else m_pend_v = 0;
                end
`endif
                if (on) m_mode = 1;
                else if (wrap) begin m_mode = 0; m_phase = 0; m_pend_v = 0; end
                else m_mode = 2;
            end
            if (m_valid && !ready) m_over = 1;
            m_valid  = 1;
            m_sample = (m_mode == 0) ? 16'h0 : wave_ref(m_phase, wave);
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
    endtask

    // ---------------- drivers / checkers ----------------
    task automatic do_reset();
        rst_n_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic step(bit tick, logic [23:0] incr, logic [1:0] wave, bit ready);
        sample_tick_in  = tick;
        phase_incr_in   = incr;
        wave_sel_in     = wave;
        sample_ready_in = ready;
        model_step(tick, int'(incr), int'(wave), ready);
        @(posedge clk_in);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
    endtask

    task automatic check_model(string tag);
        chk({tag, " sample"},  32'(sample_out),       32'(m_sample));
        chk({tag, " valid"},   32'(sample_valid_out), 32'(m_valid));
        chk({tag, " active"},  32'(active_out),       32'(m_mode != 0));
        chk({tag, " overrun"}, 32'(overrun_out),      32'(m_over));
    endtask

    task automatic check_out(string tag, logic [15:0] s, bit v, bit a, bit o);
        chk({tag, " sample"},  32'(sample_out),       32'(s));
        chk({tag, " valid"},   32'(sample_valid_out), 32'(v));
        chk({tag, " active"},  32'(active_out),       32'(a));
        chk({tag, " overrun"}, 32'(overrun_out),      32'(o));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        bit          tick;
        logic [23:0] incr;
        logic [1:0]  wave;
        bit          ready;
        logic [15:0] exp_s;
        bit          exp_v;
        bit          exp_a;
        bit          exp_o;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_tab [4][3];

    function automatic vec_t mk(bit r, bit t, logic [23:0] inc, logic [1:0] w, bit rd,
                                logic [15:0] s, bit v, bit a, bit o);
        vec_t x;
        x.rst = r; x.tick = t; x.incr = inc; x.wave = w; x.ready = rd;
        x.exp_s = s; x.exp_v = v; x.exp_a = a; x.exp_o = o;
        return x;
    endfunction

    initial begin
        logic [23:0] cur_incr;
        logic [1:0]  cur_wave;
        logic [23:0] drv_incr;
        bit          tk;

        rst_n_in = 1'b1; phase_incr_in = '0; sample_tick_in = 1'b0;
        wave_sel_in = 2'd0; sample_ready_in = 1'b0;
        model_reset();
        @(negedge clk_in);

        // Phases 0x9630, 0x12C60, 0x1C290 for each waveform.
        exp_tab[0] = '{16'h8096, 16'h812C, 16'h81C2};
        exp_tab[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        exp_tab[2] = '{16'h812C, 16'h8258, 16'h8385};
        exp_tab[3] = '{16'h0000, 16'h0000, 16'h0000};
        for (int w = 0; w < 4; w++) begin
            vecs.push_back(mk(1, 0, 24'h0, 2'(w), 1, 16'h0, 0, 0, 0));
            for (int k = 0; k < 3; k++)
                vecs.push_back(mk(0, 1, 24'h009630, 2'(w), 1, exp_tab[w][k], 1, 1, 0));
            vecs.push_back(mk(0, 0, 24'h009630, 2'(w), 1, exp_tab[w][2], 0, 1, 0));
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else step(vecs[i].tick, vecs[i].incr, vecs[i].wave, vecs[i].ready);
            check_out($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_v,
                      vecs[i].exp_a, vecs[i].exp_o);
        end

        // Release completes the current cycle, final zero sample delivered.
        do_reset();
        for (int i = 0; i < 435; i++) step(1, 24'h009630, 2'd0, 1);
        check_model("rel435");
        step(1, 24'h0, 2'd0, 1);
        check_out("rel436", 16'h7FC9, 1, 1, 0);
        step(1, 24'h0, 2'd0, 1);
        check_out("rel437", 16'h0000, 1, 0, 0);
        step(1, 24'h0, 2'd0, 1);
        check_out("rel_idle", 16'h0000, 1, 0, 0);

        // Handshake and sticky overrun.
        do_reset();
        step(1, 24'h009630, 2'd0, 0);
        check_out("hs1", 16'h8096, 1, 1, 0);
        step(1, 24'h009630, 2'd0, 0);
        check_out("hs2", 16'h812C, 1, 1, 1);
        step(0, 24'h009630, 2'd0, 1);
        check_out("hs3", 16'h812C, 0, 1, 1);
        step(1, 24'h009630, 2'd0, 1);
        check_out("hs4", 16'h81C2, 1, 1, 1);

        // Retune near the top of the cycle.
        do_reset();
        for (int i = 0; i < 435; i++) step(1, 24'h009630, 2'd0, 1);
        step(1, 24'h00B29A, 2'd0, 1);
`ifdef SYNTH_OSC_SYNC_RETUNE_EN
        chk("retune436 sample", 32'(sample_out), 32'h7FC9);
`else
        chk("retune436 sample", 32'(sample_out), 32'h7FE6);
`endif
        check_model("retune436");
        for (int i = 0; i < 4; i++) begin
            step(1, 24'h00B29A, 2'd0, 1);
            check_model($sformatf("retune%0d", 437 + i));
        end

        // Asynchronous reset mid-release, between clock edges.
        do_reset();
        for (int i = 0; i < 435; i++) step(1, 24'h009630, 2'd2, 1);
        step(1, 24'h0, 2'd2, 1);
        check_out("arst_pre", m_sample, 1, 1, 0);
        #2 rst_n_in = 1'b0;
        #1 check_out("arst", 16'h0, 0, 0, 0);
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step(1, 24'h0, 2'd2, 1);
        check_out("arst_idle", 16'h0, 1, 0, 0);

        // Randomized notes, releases, retunes, stalls and wave changes.
        do_reset();
        cur_incr = '0;
        cur_wave = 2'd0;
        for (int c = 0; c < 4000; c++) begin
            tk = ($urandom % 2) == 0;
            if ($urandom % 50 == 0) cur_wave = 2'($urandom % 4);
            if (tk && ($urandom % 16 == 0)) begin
                if ($urandom % 2 == 0) cur_incr = '0;
                else cur_incr = 24'($urandom_range(24'h3FFFFF, 1));
            end
            drv_incr = tk ? cur_incr : 24'($urandom);
            step(tk, drv_incr, cur_wave, ($urandom % 3) != 0);
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
